// File: rtl/ldtu_baseline_estimator.sv
// ldtu_baseline_estimator
// Pedestal measurement for one LiTe-DTU gain channel. After a start request it
// discards SETTLE_CYC samples, averages 2^n_log2 raw samples with round-half-up,
// subtracts a margin, clamps the result to 0..255 and publishes it with a
// one-cycle bsl_valid strobe.
// Optional build macro: LDTU_BSL_OUTLIER_REJECT_EN. It skips samples above
// REJECT_THR and aborts the measurement after 255 rejected samples.
//
// state  | meaning
// IDLE   | waiting for start; BSL_VAL holds the last result
// SETTLE | discarding samples while the input settles
// ACCUM  | summing raw samples into the accumulator
// CALC   | rounding, margin subtraction and clamping; publishes BSL_VAL

module ldtu_baseline_estimator #(
  parameter int                    Nbits_12   = 12,
  parameter int                    Nbits_8    = 8,
  parameter int                    SETTLE_CYC = 4,
  parameter logic [Nbits_12-1:0]   REJECT_THR = 12'd1000
) (
  input  logic                DCLK,
  input  logic                rst,
  input  logic                start,
  input  logic [2:0]          n_log2,
  input  logic [3:0]          bsl_margin,
  input  logic [Nbits_12-1:0] DATA12,
  output logic [Nbits_8-1:0]  BSL_VAL,
  output logic                bsl_valid,
  output logic                busy,
  output logic                sat,
  output logic                rej_err
);

  // 2^7 samples of full-scale data need 7 extra bits; one more bit leaves room
  // for the rounding term.
  localparam int ACC_W = Nbits_12 + 8;
  localparam int MAX_OUT = (1 << Nbits_8) - 1;
  localparam logic [7:0] SETTLE_LOAD = 8'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

  typedef enum logic [1:0] {IDLE, SETTLE, ACCUM, CALC} state_t;

  state_t            state;
  logic [2:0]        n_q;
  logic [3:0]        margin_q;
  logic [ACC_W-1:0]  acc;
  logic [7:0]        settle_cnt;
  logic [7:0]        smp_cnt;

  logic [7:0]        smp_load;
  logic [ACC_W-1:0]  rnd;
  logic [ACC_W-1:0]  mean;
  logic [ACC_W-1:0]  res;
  logic              take;

`ifdef LDTU_BSL_OUTLIER_REJECT_EN
  logic [7:0]        rej_cnt;
  logic              rej_err_q;

  assign take    = !(DATA12 > REJECT_THR);
  assign rej_err = rej_err_q;
`else
  // The threshold only matters when rejection is compiled in.
  logic unused_reject_thr;

  assign unused_reject_thr = ^REJECT_THR;
  assign take              = 1'b1;
  assign rej_err           = 1'b0;
`endif

  // Sample down-counter preload and the rounded, margin-adjusted mean.
  // A 3-bit n_log2 cannot exceed 7, so it is already within the legal range.
  always_comb begin
    smp_load = 8'((9'd1 << n_log2) - 9'd1);
    rnd      = (ACC_W'(1) << n_q) >> 1;
    mean     = (acc + rnd) >> n_q;
    res      = '0;
    if (ACC_W'(margin_q) <= mean) begin
      res = mean - ACC_W'(margin_q);
    end
  end

  // Measurement sequencer and registered outputs.
  always_ff @(posedge DCLK) begin
    if (rst) begin
      state      <= IDLE;
      n_q        <= '0;
      margin_q   <= '0;
      acc        <= '0;
      settle_cnt <= '0;
      smp_cnt    <= '0;
      BSL_VAL    <= '0;
      bsl_valid  <= 1'b0;
      busy       <= 1'b0;
      sat        <= 1'b0;
`ifdef LDTU_BSL_OUTLIER_REJECT_EN
      rej_cnt    <= '0;
      rej_err_q  <= 1'b0;
`endif
    end else begin
      bsl_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            n_q        <= n_log2;
            margin_q   <= bsl_margin;
            acc        <= '0;
            smp_cnt    <= smp_load;
            settle_cnt <= SETTLE_LOAD;
            sat        <= 1'b0;
            busy       <= 1'b1;
            state      <= (SETTLE_CYC == 0) ? ACCUM : SETTLE;
`ifdef LDTU_BSL_OUTLIER_REJECT_EN
            rej_cnt    <= '0;
            rej_err_q  <= 1'b0;
`endif
          end
        end
        SETTLE: begin
          if (settle_cnt == 8'd0) begin
            state <= ACCUM;
          end else begin
            settle_cnt <= settle_cnt - 8'd1;
          end
        end
        ACCUM: begin
          if (take) begin
            acc <= acc + ACC_W'(DATA12);
            if (smp_cnt == 8'd0) begin
              state <= CALC;
            end else begin
              smp_cnt <= smp_cnt - 8'd1;
            end
          end
`ifdef LDTU_BSL_OUTLIER_REJECT_EN
          else begin
            rej_cnt <= rej_cnt + 8'd1;
            // This reject is the 255th: give up without touching BSL_VAL.
            if (rej_cnt == 8'd254) begin
              rej_err_q <= 1'b1;
              busy      <= 1'b0;
              state     <= IDLE;
            end
          end
`endif
        end
        CALC: begin
          if (res > ACC_W'(MAX_OUT)) begin
            BSL_VAL <= Nbits_8'(MAX_OUT);
            sat     <= 1'b1;
          end else begin
            BSL_VAL <= res[Nbits_8-1:0];
          end
          bsl_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ldtu_baseline_estimator.md
Name: ldtu_baseline_estimator

Overview:
- Measures the ADC pedestal of one LiTe-DTU gain channel during a calibration window.
- Produces the 8-bit baseline value consumed by the baseline-subtraction stage on its BSL_VAL_g01/BSL_VAL_g10 input.
- Accumulates 2^N raw 12-bit samples after a settle period, then computes a rounded mean.
- Applies a safety margin, clamping at 0 and saturating at 255, and publishes the result with a one-cycle valid strobe.
- One instance is placed per gain channel, clocked by that channel's ADC clock.

Parameters:
- Nbits_12, 12, raw ADC sample width.
- Nbits_8, 8, baseline output width.
- SETTLE_CYC, 4, samples discarded after start (0..255; 0 skips the settle phase).
- REJECT_THR, 12'd1000, outlier threshold; used only when the optional feature is compiled in.

Ports:
- DCLK  in  1  ADC sampling clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a measurement.
- n_log2  in  3  samples to average = 2^n_log2; legal 0..7, values above 7 are treated as 7.
- bsl_margin  in  4  unsigned value subtracted from the rounded mean.
- DATA12  in  12  raw ADC sample; one sample per DCLK.
- BSL_VAL  out  8  last computed baseline; held between measurements.
- bsl_valid  out  1  one-cycle pulse when BSL_VAL updates.
- busy  out  1  high while a measurement is in progress.
- sat  out  1  sticky per measurement: the mean minus margin exceeded 255.
- rej_err  out  1  sticky per measurement: the outlier abort occurred (feature only).

Behaviour:
- Reset (rst=1 at a DCLK edge): state=IDLE, BSL_VAL=0, bsl_valid=0, busy=0, sat=0, rej_err=0, accumulator=0, all counters=0.
- Reset has priority over every other input. Reset during any state aborts the measurement; no valid pulse is issued.
- State machine: IDLE -> SETTLE -> ACCUM -> CALC -> IDLE.
- IDLE:
  - start=1 captures n_log2 (clamped to 7) and bsl_margin into internal registers.
  - It clears the accumulator, sample counter, sat and rej_err.
  - Next state is SETTLE, or ACCUM if SETTLE_CYC=0.
- SETTLE: DATA12 is ignored for exactly SETTLE_CYC cycles, then the block moves to ACCUM.
- ACCUM:
  - Each cycle, acc <= acc + DATA12 (20-bit accumulator, cannot overflow at 2^7 x 4095).
  - After 2^N accepted samples the next state is CALC.
- CALC (one cycle):
  - mean = (acc + (2^(N-1) if N>0 else 0)) >> N, i.e. round-half-up.
  - res = mean - margin; if margin > mean then res=0.
  - If res > 255 then BSL_VAL=255 and sat=1; else BSL_VAL=res[7:0].
  - BSL_VAL and bsl_valid update at the end of CALC; the state returns to IDLE.
- busy is registered: high from the cycle after start is accepted through the CALC cycle inclusive. It is low in the cycle where bsl_valid=1.
- Latency: start in cycle 0 -> bsl_valid=1 in cycle SETTLE_CYC + 2^N + 2.
- start while busy=1 is ignored; there is no queueing.
- start in the same cycle as bsl_valid is accepted, because the state is IDLE.
- n_log2 and bsl_margin changes during busy have no effect on the current measurement.
- BSL_VAL keeps its previous value throughout a new measurement until the CALC update.
- sat and rej_err hold their value until the next accepted start or reset.

Optional Feature:
- Macro: LDTU_BSL_OUTLIER_REJECT_EN.
- Enabled, in ACCUM:
  - A sample with DATA12 > REJECT_THR is not accumulated and does not advance the sample counter.
  - An 8-bit reject counter increments for each such sample.
  - When the reject counter reaches 255, the measurement aborts: rej_err=1, state goes to IDLE, BSL_VAL is unchanged and no bsl_valid pulse is issued.
- Disabled: every ACCUM sample is accumulated; rej_err is tied to 0; the REJECT_THR parameter is unused.

Test Plan:
- Constant DATA12=100, n_log2=4, margin=0, SETTLE_CYC=4, start in cycle 0 -> busy high cycles 1..21, bsl_valid in cycle 22, BSL_VAL=100, sat=0.
- DATA12 alternating 100/101, n_log2=4, margin=0 -> sum 1608, (1608+8)>>4 = 101, so BSL_VAL=101 (checks rounding).
- DATA12=1023 constant, margin=0 -> BSL_VAL=255, sat=1. Then DATA12=5, margin=8 -> BSL_VAL=0 clamp, sat=0.
- n_log2=0: single-sample path gives BSL_VAL=DATA12 of the first ACCUM cycle. Also: a start pulse while busy is ignored and the latency is unchanged.
- rst asserted in the 3rd ACCUM cycle with prior BSL_VAL=100 -> next cycle BSL_VAL=0, busy=0, no bsl_valid pulse. A new start then completes normally.
- LDTU_BSL_OUTLIER_REJECT_EN with REJECT_THR=200: ACCUM samples 100 with three 500-value spikes, n_log2=4 -> BSL_VAL=100, latency extended by 3 cycles. Continuous 500 input -> rej_err=1 after 255 rejects, no bsl_valid pulse.
